// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory load/store port: one LW/SW at a time over valid/ready,
// WAIT_CYCLES of modelled latency, then a held response carrying load data or an error flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        write_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        busy_r;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept_s;
    logic             commit_s;
    logic             cmd_write_s;
    logic [31:0]      cmd_addr_s;
    logic [31:0]      cmd_wdata_s;
    logic [3:0]       cmd_be_s;
    logic [32:0]      off_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      load_data_s;
    logic             mem_we_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Request to commit: live inputs when committing on the accept edge, latched copy otherwise.
    always_comb begin
        accept_s = req_valid && req_ready_r && (state_r == ST_IDLE);
        if (state_r == ST_IDLE) begin
            cmd_write_s = req_write;
            cmd_addr_s  = req_addr;
            cmd_wdata_s = req_wdata;
            cmd_be_s    = req_be;
        end else begin
            cmd_write_s = write_r;
            cmd_addr_s  = addr_r;
            cmd_wdata_s = wdata_r;
            cmd_be_s    = be_r;
        end
        if (WAIT_CYCLES == 32'd0) begin
            commit_s = accept_s;
        end else begin
            commit_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
        end
        // 33-bit offset: a borrow sets bit 32, so addresses below BASE_ADDR never wrap into range.
        off_s = {1'b0, cmd_addr_s} - {1'b0, BASE_ADDR};
        err_s = (off_s[1:0] != 2'b00) || off_s[32] || (off_s >= SPAN);
        idx_s = off_s[IDX_W+1:2];
        if (cmd_write_s || err_s) begin
            load_data_s = 32'd0;
        end else begin
            load_data_s = mem[idx_s];
        end
        mem_we_s = commit_s && cmd_write_s && !err_s;
    end

    // Word array; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem[idx_s] <= merge_bytes(mem[idx_s], cmd_wdata_s, cmd_be_s);
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            be_r        <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r     <= req_write;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        be_r        <= req_be;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (WAIT_CYCLES == 32'd0) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= err_s;
                            rsp_rdata_r <= load_data_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= err_s;
                        rsp_rdata_r <= load_data_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance, each checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_data_mem_responder;

    localparam int WC [2] = '{2, 0};
    localparam longint BASE = 0;
    localparam longint DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        rv    [2];
    logic        rrdy  [2];
    logic        rwr   [2];
    logic [31:0] ra    [2];
    logic [31:0] rwd   [2];
    logic [3:0]  rbe   [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
        .clock(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(req_ready[0]),
        .req_write(rwr[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .req_be(rbe[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rrdy[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]));

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(req_ready[1]),
        .req_write(rwr[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .req_be(rbe[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rrdy[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a transaction is outstanding from accept until the response handshake;
    // the response appears WC edges after the accept edge and reflects the memory at that point.
    bit          out_m  [2] = '{1'b0, 1'b0};
    bit          resp_m [2] = '{1'b0, 1'b0};
    int          age_m  [2];
    bit          w_m    [2];
    logic [31:0] a_m    [2];
    logic [31:0] d_m    [2];
    logic [3:0]  be_m   [2];
    logic [31:0] exp_d  [2];
    bit          exp_e  [2];
    bit   [31:0] mm     [2][256];

    task automatic deliver(input int k);
        longint off;
        bit e;
        int w;
        off = longint'(a_m[k]) - BASE;
        e = (a_m[k][1:0] != 2'b00) || (off < 0) || (off >= 4 * DEPTH);
        resp_m[k] = 1'b1;
        exp_e[k] = e;
        exp_d[k] = 32'd0;
        if (!e) begin
            w = int'(off / 4);
            if (w_m[k]) begin
                for (int i = 0; i < 4; i++)
                    if (be_m[k][i]) mm[k][w][8*i +: 8] = d_m[k][8*i +: 8];
            end else begin
                exp_d[k] = mm[k][w];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                out_m[k] = 1'b0;
                resp_m[k] = 1'b0;
            end else if (!out_m[k]) begin
                if (rv[k]) begin
                    out_m[k] = 1'b1;
                    age_m[k] = 0;
                    w_m[k] = rwr[k];
                    a_m[k] = ra[k];
                    d_m[k] = rwd[k];
                    be_m[k] = rbe[k];
                    if (WC[k] == 0) deliver(k);
                end
            end else if (!resp_m[k]) begin
                age_m[k]++;
                if (age_m[k] == WC[k]) deliver(k);
            end else if (rrdy[k]) begin
                out_m[k] = 1'b0;
                resp_m[k] = 1'b0;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(resp_m[k]));
                chk($sformatf("u%0d req_ready", k), 32'(req_ready[k]), 32'(!out_m[k]));
                chk($sformatf("u%0d busy", k), 32'(busy[k]), 32'(out_m[k]));
                if (resp_m[k]) begin
                    chk($sformatf("u%0d rsp_rdata", k), rsp_rdata[k], exp_d[k]);
                    chk($sformatf("u%0d rsp_err", k), 32'(rsp_err[k]), 32'(exp_e[k]));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic xact(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] xd, input bit xe,
                        input int stall, input string nm);
        int g;
        int lat;
        tick();
        rv[k] = 1'b1; rwr[k] = wr; ra[k] = a; rwd[k] = wd; rbe[k] = be;
        rrdy[k] = (stall == 0);
        g = 0;
        while (!req_ready[k] && g < 20) begin tick(); g++; end
        chk({nm, " ready"}, 32'(req_ready[k]), 32'd1);
        tick();
        rv[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin tick(); lat++; end
        chk({nm, " latency"}, 32'(lat), (k == 0) ? 32'd3 : 32'd1);
        chk({nm, " rdata"}, rsp_rdata[k], xd);
        chk({nm, " err"}, 32'(rsp_err[k]), 32'(xe));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({nm, " hold valid"}, 32'(rsp_valid[k]), 32'd1);
            chk({nm, " hold rdata"}, rsp_rdata[k], xd);
            chk({nm, " hold ready"}, 32'(req_ready[k]), 32'd0);
        end
        rrdy[k] = 1'b1;
        tick();
        chk({nm, " retire valid"}, 32'(rsp_valid[k]), 32'd0);
        chk({nm, " retire ready"}, 32'(req_ready[k]), 32'd1);
    endtask

    task automatic reset_vals(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, " req_ready"}, 32'(req_ready[k]), 32'd1);
            chk({nm, " rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
            chk({nm, " busy"}, 32'(busy[k]), 32'd0);
            chk({nm, " rsp_rdata"}, rsp_rdata[k], 32'd0);
            chk({nm, " rsp_err"}, 32'(rsp_err[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int g;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; rrdy[k] = 1'b1; rwr[k] = 1'b0;
            ra[k] = 32'd0; rwd[k] = 32'd0; rbe[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        reset_vals("reset");
        chk_en = 1'b1;

        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, "t1 sw");
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "t1 lw");

        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0, "t2 sw full");
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0, "t2 sw part");
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0, "t2 lw");
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0, "t2 sw be0");
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0, "t2 lw be0");

        xact(0, 1'b1, 32'h0, 32'h55AA0F0F, 4'hF, 32'h0, 1'b0, 0, "t3 sw w0");
        xact(0, 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0, "t3 lw misalign");
        xact(0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 0, "t3 lw range");
        xact(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0, "t3 sw range");
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h55AA0F0F, 1'b0, 0, "t3 lw w0");
        xact(0, 1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0, 1'b0, 0, "t3 sw last");
        xact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, "t3 lw last");

        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5, "t4 stall");

        xact(0, 1'b1, 32'h30, 32'h01020304, 4'hF, 32'h0, 1'b0, 0, "t5 sw prior");
        tick();
        rv[0] = 1'b1; rwr[0] = 1'b1; ra[0] = 32'h30; rwd[0] = 32'hCAFEF00D; rbe[0] = 4'hF;
        chk("t5 ready", 32'(req_ready[0]), 32'd1);
        tick();
        rv[0] = 1'b0;
        tick();
        chk("t5 in wait", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_vals("t5 reset");
        tick();
        rst_n = 1'b1;
        tick();
        reset_vals("t5 after");
        xact(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h01020304, 1'b0, 0, "t5 lw");

        for (int i = 0; i < 4; i++)
            xact(1, 1'b1, 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 32'h0, 1'b0, 0, "t6 sw");
        tick();
        rv[1] = 1'b1; rwr[1] = 1'b0; rrdy[1] = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            g = 0;
            while (!req_ready[1] && g < 10) begin tick(); g++; end
            chk("t6 ready", 32'(req_ready[1]), 32'd1);
            ra[1] = 32'(4 * i);
            if (i > 0) chk("t6 spacing", 32'(cyc - prev), 32'd2);
            prev = cyc;
            tick();
            chk("t6 rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("t6 rdata", rsp_rdata[1], 32'hA0000000 + 32'(i));
        end
        rv[1] = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
